// File: rtl/ov5640_init_sequencer.sv
// OV5640 power-up register sequencer.
// Walks the init table, issues one SCCB write per entry, inserts the power-up
// wait and the settle wait after the software-reset write, retries NACKs, and
// reports init_done / init_error to the camera top level.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// PWRUP_WAIT | wait PWRUP_CYCLES after reset/restart before the first fetch
// FETCH      | rom_addr already holds index; one cycle for the ROM latency
// LATCH      | capture table entry (first attempt only), raise wr_req
// WRITE      | hold request stable until wr_done; route on ack/nack
// SETTLE     | wait RESET_WAIT_CYCLES after the software-reset write
// NEXT       | advance index or finish
// DONE       | all entries written; idle until restart
// ERROR      | retries exhausted on cur_index; idle until restart
module ov5640_init_sequencer #(
   parameter int ADDR_WIDTH        = 8,
   parameter int DATA_WIDTH        = 24,
   parameter int INIT_NUM          = 252,
   parameter int PWRUP_CYCLES      = 1000000,
   parameter int RESET_INDEX       = 1,
   parameter int RESET_WAIT_CYCLES = 250000,
   parameter int RETRY_MAX         = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  restart,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic                  wr_req,
   output logic [15:0]           wr_reg_addr,
   output logic [7:0]            wr_reg_data,
   input  logic                  wr_done,
   input  logic                  wr_nack,
   output logic                  init_done,
   output logic                  init_error,
   output logic [ADDR_WIDTH-1:0] cur_index
);

   localparam int CNT_MAX = (PWRUP_CYCLES > RESET_WAIT_CYCLES) ? PWRUP_CYCLES : RESET_WAIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

   localparam logic [CNT_W-1:0]      PWRUP_LAST  = CNT_W'(PWRUP_CYCLES - 1);
   localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(RESET_WAIT_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(INIT_NUM - 1);
   localparam logic [ADDR_WIDTH-1:0] RST_IDX     = ADDR_WIDTH'(RESET_INDEX);
   localparam logic [RETRY_W-1:0]    RETRY_LIM   = RETRY_W'(RETRY_MAX);

   typedef enum logic [2:0] {
      S_PWRUP_WAIT = 3'd0,
      S_FETCH      = 3'd1,
      S_LATCH      = 3'd2,
      S_WRITE      = 3'd3,
      S_SETTLE     = 3'd4,
      S_NEXT       = 3'd5,
      S_DONE       = 3'd6,
      S_ERROR      = 3'd7
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] idx, idx_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [RETRY_W-1:0]    retry, retry_nxt;
   logic                  req, req_nxt;
   logic [15:0]           reg_addr, reg_addr_nxt;
   logic [7:0]            reg_data, reg_data_nxt;
   logic                  done, done_nxt;
   logic                  err, err_nxt;

   // The index flop drives the ROM address directly, so the address is valid
   // from the edge that enters FETCH and the entry is ready by LATCH.
   assign rom_addr    = idx;
   assign cur_index   = idx;
   assign wr_req      = req;
   assign wr_reg_addr = reg_addr;
   assign wr_reg_data = reg_data;
   assign init_done   = done;
   assign init_error  = err;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_PWRUP_WAIT;
      else        state <= state_nxt;
   end

   // Next-state decode; restart overrides everything, including a wr_done
   always_comb begin
      state_nxt = state;
      if (restart) begin
         state_nxt = S_PWRUP_WAIT;
      end else begin
         case (state)
            S_PWRUP_WAIT: if (cnt == PWRUP_LAST) state_nxt = S_FETCH;
            S_FETCH:      state_nxt = S_LATCH;
            S_LATCH:      state_nxt = S_WRITE;
            S_WRITE: begin
               if (wr_done) begin
                  if (!wr_nack)                state_nxt = (idx == RST_IDX) ? S_SETTLE : S_NEXT;
                  else if (retry == RETRY_LIM) state_nxt = S_ERROR;
                  else                         state_nxt = S_LATCH;
               end
            end
            S_SETTLE:     if (cnt == SETTLE_LAST) state_nxt = S_NEXT;
            S_NEXT:       state_nxt = (idx == LAST_IDX) ? S_DONE : S_FETCH;
            S_DONE:       state_nxt = S_DONE;
            S_ERROR:      state_nxt = S_ERROR;
            default:      state_nxt = S_PWRUP_WAIT;
         endcase
      end
   end

   // Next values of the datapath and the registered outputs
   always_comb begin
      idx_nxt      = idx;
      cnt_nxt      = cnt;
      retry_nxt    = retry;
      req_nxt      = req;
      reg_addr_nxt = reg_addr;
      reg_data_nxt = reg_data;
      done_nxt     = done;
      err_nxt      = err;
      if (restart) begin
         idx_nxt   = '0;
         cnt_nxt   = '0;
         retry_nxt = '0;
         req_nxt   = 1'b0;
         done_nxt  = 1'b0;
         err_nxt   = 1'b0;
      end else begin
         case (state)
            S_PWRUP_WAIT: begin
               if (cnt == PWRUP_LAST) begin
                  cnt_nxt = '0;
                  idx_nxt = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            S_LATCH: begin
               // A retry re-sends the entry captured on the first attempt.
               if (retry == '0) begin
                  reg_addr_nxt = rom_q[23:8];
                  reg_data_nxt = rom_q[7:0];
               end
               req_nxt = 1'b1;
            end
            S_WRITE: begin
               if (wr_done) begin
                  req_nxt = 1'b0;
                  if (!wr_nack)                retry_nxt = '0;
                  else if (retry == RETRY_LIM) err_nxt   = 1'b1;
                  else                         retry_nxt = retry + 1'b1;
               end
            end
            S_SETTLE: begin
               if (cnt == SETTLE_LAST) cnt_nxt = '0;
               else                    cnt_nxt = cnt + 1'b1;
            end
            S_NEXT: begin
               if (idx == LAST_IDX) done_nxt = 1'b1;
               else                 idx_nxt  = idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         cnt      <= '0;
         retry    <= '0;
         req      <= 1'b0;
         reg_addr <= '0;
         reg_data <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         idx      <= idx_nxt;
         cnt      <= cnt_nxt;
         retry    <= retry_nxt;
         req      <= req_nxt;
         reg_addr <= reg_addr_nxt;
         reg_data <= reg_data_nxt;
         done     <= done_nxt;
         err      <= err_nxt;
      end
   end

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Self-checking bench for ov5640_init_sequencer with a 4-entry table,
// a synchronous ROM model and an SCCB model that answers 3 clk after wr_req.
module tb_ov5640_init_sequencer;

   localparam int AW    = 8;
   localparam int DW    = 24;
   localparam int N     = 4;
   localparam int PWR   = 10;
   localparam int RWAIT = 20;
   localparam int RIDX  = 1;
   localparam int RMAX  = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          restart = 1'b0;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_q;
   logic          wr_req;
   logic [15:0]   wr_reg_addr;
   logic [7:0]    wr_reg_data;
   logic          wr_done = 1'b0;
   logic          wr_nack = 1'b0;
   logic          init_done;
   logic          init_error;
   logic [AW-1:0] cur_index;

   ov5640_init_sequencer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_NUM(N), .PWRUP_CYCLES(PWR),
      .RESET_INDEX(RIDX), .RESET_WAIT_CYCLES(RWAIT), .RETRY_MAX(RMAX)
   ) dut (
      .clk(clk), .rst_n(rst_n), .restart(restart), .rom_addr(rom_addr), .rom_q(rom_q),
      .wr_req(wr_req), .wr_reg_addr(wr_reg_addr), .wr_reg_data(wr_reg_data),
      .wr_done(wr_done), .wr_nack(wr_nack), .init_done(init_done),
      .init_error(init_error), .cur_index(cur_index)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [23:0] rom_mem [N];
   initial begin
      rom_mem[0] = 24'h310311;
      rom_mem[1] = 24'h300882;
      rom_mem[2] = 24'h300842;
      rom_mem[3] = 24'h310303;
   end

   // Synchronous table ROM, one clock of read latency
   always @(posedge clk) rom_q <= (int'(rom_addr) < N) ? rom_mem[int'(rom_addr) % N] : 24'hBAD0BA;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t exp_q[$];
   int  rise_cyc [N];
   int  done_cyc [N];
   bit  seen     [N];
   int  nack_left[N];
   int  rises;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected write stream for a run where entry nack_idx is NACKed nack_cnt times
   task automatic prep_run(input int nack_idx, input int nack_cnt);
      int attempts;
      exp_q.delete();
      rises = 0;
      for (int i = 0; i < N; i++) begin
         nack_left[i] = (i == nack_idx) ? nack_cnt : 0;
         seen[i]      = 1'b0;
         rise_cyc[i]  = 0;
         done_cyc[i]  = 0;
      end
      for (int i = 0; i < N; i++) begin
         attempts = 1;
         if (i == nack_idx) attempts = (nack_cnt > RMAX) ? RMAX + 1 : nack_cnt + 1;
         for (int k = 0; k < attempts; k++) exp_q.push_back(wr_t'(rom_mem[i]));
         if (i == nack_idx && nack_cnt > RMAX) break;
      end
   endtask

   // SCCB slave model: done (with optional nack) 3 clk after each wr_req rise
   logic m_prev = 1'b0;
   int   m_idx;
   initial begin
      forever begin
         @(posedge clk); #1;
         if (wr_req && !m_prev) begin
            m_idx = int'(cur_index);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            wr_done = 1'b1;
            wr_nack = 1'b0;
            if (m_idx < N) begin
               if (nack_left[m_idx] > 0) begin
                  wr_nack = 1'b1;
                  nack_left[m_idx]--;
               end
               done_cyc[m_idx] = cyc + 1;
            end
            @(negedge clk);
            wr_done = 1'b0;
            wr_nack = 1'b0;
            m_prev  = 1'b0;
         end else begin
            m_prev = wr_req;
         end
      end
   end

   // Write monitor: scoreboard pop on each wr_req rise, hold check while high
   logic          p_req = 1'b0;
   logic [AW-1:0] p_addr = '0;
   int            addr_chg = 0;
   wr_t           held;
   wr_t           mon_e;
   int            ci;
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rom_addr !== p_addr) addr_chg = cyc;
         p_addr = rom_addr;
         if (wr_req && !p_req) begin
            rises++;
            ci = int'(cur_index);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wr_req: actual addr=%0h data=%0h index=%0d required=no request",
                        wr_reg_addr, wr_reg_data, ci);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_reg_addr", wr_reg_addr, mon_e.a);
               check("wr_reg_data", wr_reg_data, mon_e.d);
            end
            held = {wr_reg_addr, wr_reg_data};
            if (ci < N && !seen[ci]) begin
               seen[ci]     = 1'b1;
               rise_cyc[ci] = cyc;
               if (ci != 0) check("fetch_to_req_clks", cyc - addr_chg, 2);
            end
         end else if (wr_req && p_req) begin
            check("req_hold_stable", {wr_reg_addr, wr_reg_data}, held);
         end
         p_req = wr_req;
      end
   end

   task automatic assert_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_outputs", {rom_addr, wr_req, wr_reg_addr, wr_reg_data, init_done, init_error, cur_index}, '0);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic wait_end(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk); #1;
         if (init_done || init_error) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      int nack_idx;
      int nack_cnt;
      bit exp_done;
      bit exp_err;
      int exp_idx;
      int exp_writes;
   } vec_t;

   vec_t vecs[4];
   bit   ok;
   int   rcyc;

   initial begin
      vecs[0] = '{-1, 0, 1'b1, 1'b0, 3, 4};
      vecs[1] = '{ 2, 2, 1'b1, 1'b0, 3, 6};
      vecs[2] = '{ 2, 4, 1'b0, 1'b1, 2, 6};
      vecs[3] = '{ 1, 1, 1'b1, 1'b0, 3, 5};

      for (int v = 0; v < 4; v++) begin
         assert_reset();
         prep_run(vecs[v].nack_idx, vecs[v].nack_cnt);
         rst_n = 1'b1;
         wait_end(600, ok);
         check("run_completes", ok, 1);
         repeat (10) @(posedge clk);
         #1;
         check("init_done", init_done, vecs[v].exp_done);
         check("init_error", init_error, vecs[v].exp_err);
         check("cur_index", cur_index, vecs[v].exp_idx);
         check("wr_req_idle", wr_req, 0);
         check("write_count", rises, vecs[v].exp_writes);
         check("writes_left", exp_q.size(), 0);
         if (v == 0) begin
            check("settle_gap_ge_wait", (rise_cyc[2] - done_cyc[1]) >= RWAIT, 1);
            check("no_settle_gap_e0_e1", (rise_cyc[1] - done_cyc[0]) < RWAIT, 1);
            // a wr_done while idle in DONE must change nothing
            @(negedge clk);
            wr_done = 1'b1;
            @(negedge clk);
            wr_done = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("stray_done_in_done", {init_done, init_error, wr_req, cur_index}, {1'b1, 1'b0, 1'b0, 8'd3});
         end
      end

      // restart while entry 3 is in flight
      assert_reset();
      prep_run(-1, 0);
      rst_n = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(posedge clk); #1;
         if (wr_req && cur_index == 8'd3) begin
            ok = 1'b1;
            break;
         end
      end
      check("reach_entry3", ok, 1);
      restart = 1'b1;
      @(posedge clk);
      rcyc = cyc;
      #1;
      restart = 1'b0;
      check("restart_drops_req", {wr_req, init_done, init_error, cur_index}, '0);
      prep_run(-1, 0);
      wait_end(600, ok);
      check("restart_run_completes", ok, 1);
      check("restart_pwrup_gap", (rise_cyc[0] - rcyc >= PWR + 2) && (rise_cyc[0] - rcyc <= PWR + 3), 1);
      check("restart_done", {init_done, init_error}, 2'b10);
      check("restart_writes", rises, 4);

      // asynchronous reset in the middle of SETTLE
      assert_reset();
      prep_run(-1, 0);
      rst_n = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(posedge clk); #1;
         if (done_cyc[1] != 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("reach_settle", ok, 1);
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {rom_addr, wr_req, wr_reg_addr, wr_reg_data, init_done, init_error, cur_index}, '0);
      @(negedge clk);
      prep_run(-1, 0);
      rst_n = 1'b1;
      wait_end(600, ok);
      check("post_reset_completes", ok, 1);
      check("post_reset_done", {init_done, init_error, cur_index}, {2'b10, 8'd3});
      check("post_reset_writes", rises, 4);
      check("post_reset_left", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
